// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the core/memory bridge: state encoding, default
// bus widths and instruction field positions also used by the control unit.
package mips_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   // Instruction field positions, shared with the control unit decoder
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned FUNCT_MSB  = 5;
   localparam int unsigned FUNCT_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } bridge_state_t;

   function automatic logic [5:0] opcode_of(input logic [31:0] ir);
      return ir[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [5:0] funct_of(input logic [31:0] ir);
      return ir[FUNCT_MSB:FUNCT_LSB];
   endfunction

endpackage

// File: rtl/mem_bridge_timer.sv
// Access watchdog: counts cycles while enabled, flags the last allowed cycle.
module bridge_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Cycle counter, held at zero whenever the bridge is not waiting on memory
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/mem_bridge.sv
// Bridge between the multi-cycle core and the unified instruction/data memory:
// one access per request, req/ack handshake, IR and MDR holding, ready pulse.
module mem_bridge
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_ir_load,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] mdr,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   bridge_state_t state, state_nx;
   logic          ir_load_q;
   logic          expired;

   bridge_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != BUSY),
      .enable  (state == BUSY),
      .expired (expired)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; an ack on the last allowed cycle still completes normally
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (cpu_req) state_nx = BUSY;
         BUSY:    if (mem_ack || expired) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch, memory-side outputs, IR/MDR capture, ready pulse and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ir_load_q <= 1'b0;
         cpu_ready <= 1'b0;
         instr     <= '0;
         mdr       <= '0;
         bus_err   <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cpu_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= cpu_we;
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
                  ir_load_q <= cpu_ir_load;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  cpu_ready <= 1'b1;
                  if (!mem_we) begin
                     mdr <= mem_rdata;
                     if (ir_load_q) begin
                        instr <= mem_rdata;
                     end
                  end
               end else if (expired) begin
                  mem_req   <= 1'b0;
                  cpu_ready <= 1'b1;
                  bus_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits between the multi-cycle core (control unit plus datapath) and the single unified instruction/data memory.
- Accepts one access per request from the core, runs a req/ack handshake with a variable-latency memory, and holds the instruction register and memory data register.
- Returns a one-cycle ready pulse so the control FSM can stall in fetch and memory states until the access finishes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles in BUSY before the access aborts with a bus error (must be at least 1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  core requests an access; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_ir_load  in  1  read is an instruction fetch (the control unit's ir_write)
- cpu_addr  in  ADDR_W  byte address, already selected by the IorD mux
- cpu_wdata  in  DATA_W  store data
- cpu_ready  out  1  one-cycle pulse: access finished
- instr  out  DATA_W  instruction register; opcode and funct fields go to the control unit
- mdr  out  DATA_W  memory data register
- bus_err  out  1  sticky flag: an access timed out
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  write data to memory
- mem_ack  in  1  single-cycle completion from memory
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_ready=0, instr=0, mdr=0, bus_err=0.
- IDLE:
  - If cpu_req=1 at the edge: latch cpu_we, cpu_ir_load, cpu_addr, cpu_wdata; go to BUSY.
  - mem_req, mem_we, mem_addr, mem_wdata are registered and driven from the next cycle.
- BUSY:
  - mem_req=1; mem_we, mem_addr, mem_wdata hold their latched values.
  - counter increments each cycle.
  - On mem_ack=1 at the edge:
    - Read: mdr<=mem_rdata. If ir_load was latched, also instr<=mem_rdata.
    - Write: no register update.
    - Go to DONE; mem_req drops in the same edge.
  - If the counter reaches TIMEOUT-1 with no ack: bus_err<=1, mem_req<=0, instr and mdr unchanged, go to DONE.
  - mem_ack and the timeout in the same cycle: the ack wins and bus_err is not set.
- DONE:
  - cpu_ready=1 for exactly this cycle; counter clears; go to IDLE.
  - cpu_req is ignored here, so a request held high through the ready cycle issues once. A new request is taken in the following IDLE cycle.
- Latency:
  - cpu_req sampled at edge N gives mem_req=1 from N+1.
  - With mem_ack at edge N+k (k≥1), cpu_ready is high in cycle N+k.
  - Minimum request-to-ready is 2 cycles. Back-to-back accesses take at least 3 cycles each.
- mem_ack outside BUSY is ignored; it is spurious and has no effect.
- cpu_req, cpu_we, cpu_addr and cpu_wdata are don't-care outside IDLE.
- bus_err clears only on rst. Later accesses still run normally while it is set.
- Reset during BUSY: mem_req drops asynchronously; memory must abandon the transaction; any in-flight data is discarded.
- instr and mdr change only on an acked read, never on a write or a timeout.

Decomposition:
- Package mips_mem_pkg:
  - bridge_state_t enum {IDLE, BUSY, DONE}
  - default widths ADDR_W/DATA_W
  - opcode and funct field bit positions, shared with the control unit
- Sub-module bridge_timer:
  - Inputs: clear, enable.
  - Output: expired, high when count = TIMEOUT-1.
  - Width: $clog2(TIMEOUT+1).
- The FSM, request latch and instr/mdr registers stay in mem_bridge.

Test Plan:
- Reset: assert rst mid-BUSY with mem_req=1 -> mem_req, cpu_ready, instr, mdr and bus_err are 0 immediately; state is IDLE.
- Fetch, zero wait: cpu_req=1, cpu_ir_load=1, cpu_addr=0x0000_0004; mem_ack the first cycle mem_req is high with mem_rdata=0x8C02_0008 -> mem_addr=0x4; instr=mdr=0x8C02_0008; cpu_ready pulses once, 2 cycles after the request.
- Load with wait states: cpu_ir_load=0, ack after 5 cycles with rdata=0xDEAD_BEEF -> mdr=0xDEAD_BEEF, instr unchanged, mem_req high for exactly 5 cycles, one cpu_ready pulse.
- Store: cpu_we=1, addr=0x10, wdata=0x1234_5678 -> mem_we=1 and mem_wdata=0x1234_5678 while mem_req is high; instr and mdr unchanged after ack.
- Timeout with TIMEOUT=4, no ack -> mem_req high 4 cycles, then bus_err=1 (sticky) and one cpu_ready pulse; the next fetch still completes.
- cpu_req held high through DONE plus a spurious mem_ack in IDLE -> exactly one memory transaction per held request; spurious ack causes no register change and no cpu_ready.
